// File: rtl/mul_pkg.sv
// Shared types and default widths for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int A_WIDTH_DEF = 32;
    localparam int B_WIDTH_DEF = 32;
    localparam int P_WIDTH_DEF = A_WIDTH_DEF + B_WIDTH_DEF;
    localparam int CNT_W_DEF   = $clog2(B_WIDTH_DEF + 1);

endpackage

// File: rtl/mul_sign_fix.sv
// Two's-complement helpers for the signed build: operand magnitudes and result negation.
module mul_sign_fix #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic [A_WIDTH-1:0] i_a,
    input  logic [B_WIDTH-1:0] i_b,
    input  logic [P_WIDTH-1:0] i_acc,
    input  logic               i_neg,
    output logic [A_WIDTH-1:0] o_a_abs,
    output logic [B_WIDTH-1:0] o_b_abs,
    output logic               o_sign,
    output logic [P_WIDTH-1:0] o_result
);

    // The most-negative value negates to itself, which is its exact unsigned magnitude.
    assign o_a_abs  = i_a[A_WIDTH-1] ? (-i_a) : i_a;
    assign o_b_abs  = i_b[B_WIDTH-1] ? (-i_b) : i_b;
    assign o_sign   = i_a[A_WIDTH-1] ^ i_b[B_WIDTH-1];
    assign o_result = i_neg ? (-i_acc) : i_acc;

endmodule

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier, one multiplier bit per clock.
// Define MUL_SEQ_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module mul_seq
    import mul_pkg::*;
#(
    parameter  int A_WIDTH = A_WIDTH_DEF,
    parameter  int B_WIDTH = B_WIDTH_DEF,
    localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [A_WIDTH-1:0] multiplicand,
    input  logic [B_WIDTH-1:0] multiplier,
    output logic               ready,
    output logic [P_WIDTH-1:0] product,
    output logic               valid_out
);

    localparam int CNT_W = $clog2(B_WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_ready;
    logic               w_accept;
    logic [P_WIDTH-1:0] r_a_sh;
    logic [B_WIDTH-1:0] r_b;
    logic [P_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [P_WIDTH-1:0] r_product;
    logic               r_valid_out;
    logic [A_WIDTH-1:0] w_a_abs;
    logic [B_WIDTH-1:0] w_b_abs;
    logic [P_WIDTH-1:0] w_result;

    assign w_accept  = valid_in && w_ready;
    assign ready     = w_ready;
    assign product   = r_product;
    assign valid_out = r_valid_out;

`ifdef MUL_SEQ_SIGNED_EN
    logic r_sign;
    logic w_sign;

    mul_sign_fix #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .P_WIDTH (P_WIDTH)
    ) u_sign_fix (
        .i_a      (multiplicand),
        .i_b      (multiplier),
        .i_acc    (r_acc),
        .i_neg    (r_sign),
        .o_a_abs  (w_a_abs),
        .o_b_abs  (w_b_abs),
        .o_sign   (w_sign),
        .o_result (w_result)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_sign <= w_sign;
        end
    end
`else
    assign w_a_abs  = multiplicand;
    assign w_b_abs  = multiplier;
    assign w_result = r_acc;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (r_cnt == CNT_W'(B_WIDTH - 1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = w_accept ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Ready is gated by reset so no operand can be accepted while reset is held.
    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            IDLE:    w_ready = reset;
            DONE:    w_ready = reset;
            default: w_ready = 1'b0;
        endcase
    end

    // Acceptance in DONE reloads the core on the same edge the finished result is registered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_a_sh      <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (w_accept) begin
                r_a_sh <= P_WIDTH'(w_a_abs);
                r_b    <= w_b_abs;
                r_acc  <= '0;
                r_cnt  <= '0;
            end else if (r_state == RUN) begin
                if (r_b[0]) begin
                    r_acc <= r_acc + r_a_sh;
                end
                r_a_sh <= r_a_sh << 1;
                r_b    <= r_b >> 1;
                r_cnt  <= r_cnt + CNT_W'(1);
            end
            if (r_state == DONE) begin
                r_product   <= w_result;
                r_valid_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq (default 32x32 build).
module tb_mul_seq;

    logic        clock;
    logic        reset;
    logic        valid_in;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        ready;
    logic [63:0] product;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    mul_seq dut (
        .clock        (clock),
        .reset        (reset),
        .valid_in     (valid_in),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .product      (product),
        .valid_out    (valid_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation: accept on the next posedge, then watch 36 edges for the single result pulse.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit poke);
        int first_k;
        int pulses;
        @(negedge clock);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        valid_in     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clock);
        #1;
        valid_in     = 1'b0;
        multiplicand = 32'hDEADBEEF;
        multiplier   = 32'hCAFEF00D;
        first_k = 0;
        pulses  = 0;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clock);
            #1;
            if (poke && k == 5) begin
                chk({tag, "_busy"}, 64'(ready), 64'd0);
                valid_in     = 1'b1;
                multiplicand = 32'd7;
                multiplier   = 32'd9;
            end
            if (poke && k == 6) valid_in = 1'b0;
            if (valid_out) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            if (k == 33) chk({tag, "_product"}, product, exp);
        end
        chk({tag, "_latency"}, 64'(first_k), 64'd33);
        chk({tag, "_pulses"}, 64'(pulses), 64'd1);
        chk({tag, "_hold"}, product, exp);
    endtask

    initial begin
        int pulses;
        reset        = 1'b0;
        valid_in     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_product", product, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rel_ready", 64'(ready), 64'd1);

        // Basic, max, zero, busy rejection
        run_op("basic", 32'd64, 32'd4, 64'd256, 1'b0);
        run_op("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0);
        run_op("zero", 32'd0, 32'h12345678, 64'd0, 1'b0);
        run_op("busy", 32'd12, 32'd11, 64'd132, 1'b1);

        // Back-to-back: valid_in held high, second operands presented in the DONE cycle
        @(negedge clock);
        valid_in     = 1'b1;
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        @(posedge clock);
        #1;
        pulses = 0;
        for (int k = 1; k <= 67; k++) begin
            @(posedge clock);
            #1;
            if (valid_out) pulses++;
            if (k == 32) begin
                chk("b2b_done_ready", 64'(ready), 64'd1);
                multiplicand = 32'd10;
                multiplier   = 32'd10;
            end
            if (k == 33) begin
                chk("b2b_valid1", 64'(valid_out), 64'd1);
                chk("b2b_product1", product, 64'd15);
                chk("b2b_run_ready", 64'(ready), 64'd0);
                valid_in = 1'b0;
            end
            if (k == 65) chk("b2b_done2_ready", 64'(ready), 64'd1);
            if (k == 66) begin
                chk("b2b_valid2", 64'(valid_out), 64'd1);
                chk("b2b_product2", product, 64'd100);
            end
        end
        chk("b2b_pulses", 64'(pulses), 64'd2);

        // Reset mid-operation
        @(negedge clock);
        valid_in     = 1'b1;
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        pulses   = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clock);
            #1;
            if (valid_out) pulses++;
            if (k == 10) reset = 1'b0;
            if (k == 12) begin
                chk("mid_rst_ready", 64'(ready), 64'd0);
                reset = 1'b1;
            end
        end
        chk("mid_rst_pulses", 64'(pulses), 64'd0);
        chk("mid_rst_product", product, 64'd0);
        run_op("after_rst", 32'd2, 32'd3, 64'd6, 1'b0);

`ifdef MUL_SEQ_SIGNED_EN
        run_op("sgn_neg", 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFFFFFFFFF1, 1'b0);
        run_op("sgn_min", 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
